// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// default sizing for the requester count and tx_busy launch timeout.
package uart_pkg;

  localparam int DEF_NREQ         = 4;
  localparam int DEF_BUSY_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: scans the request vector starting at i_ptr and
// wrapping modulo NREQ; returns the first asserted requester as index and one-hot.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic                    o_valid,
  output logic [NREQ-1:0]         o_onehot,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int IW = $clog2(NREQ);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_pos;

  always_comb begin
    o_valid  = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    w_sum    = '0;
    w_pos    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // i_ptr + k wrapped into 0..NREQ-1 without a divider
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) begin
        w_sum = w_sum - (IW+1)'(NREQ);
      end
      w_pos = w_sum[IW-1:0];
      if (!o_valid && i_req[w_pos]) begin
        o_valid         = 1'b1;
        o_idx           = w_pos;
        o_onehot[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NREQ byte requesters. Round-robin by default;
// define UART_ARB_FIXED_PRI_EN for fixed priority (lowest index wins, no pointer).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = DEF_NREQ,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NREQ-1:0]         i_req,
  input  logic [8*NREQ-1:0]       i_req_data,
  output logic [NREQ-1:0]         o_gnt,
  output logic [NREQ-1:0]         o_done,
  output logic                    o_err,
  output logic                    o_tx_start,
  output logic [7:0]              o_tx_data,
  input  logic                    i_tx_busy,
  output logic [$clog2(NREQ)-1:0] o_owner,
  output arb_state_e              o_state
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  // Handshake: a requester holds i_req[i] high with stable data until o_gnt[i]
  // pulses; the arbiter only samples requests in IDLE while i_tx_busy is low.
  arb_state_e    r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          r_start, w_start_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic          w_pick_valid;
  logic [NREQ-1:0] w_pick_onehot;
  logic [IW-1:0] w_pick_idx;
  logic [IW-1:0] w_ptr;
  logic          w_launch;

  assign w_launch = (r_state == ST_IDLE) && w_pick_valid && !i_tx_busy;

`ifdef UART_ARB_FIXED_PRI_EN
  assign w_ptr = '0;
`else
  logic [IW-1:0] r_ptr, w_ptr_nxt;

  assign w_ptr = r_ptr;

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_launch) begin
      w_ptr_nxt = (w_pick_idx == IW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
`endif

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (i_req),
    .i_ptr    (w_ptr),
    .o_valid  (w_pick_valid),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    w_err_nxt   = 1'b0;
    w_start_nxt = 1'b0;
    w_data_nxt  = r_data;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_state_nxt = ST_LAUNCH;
          w_gnt_nxt   = w_pick_onehot;
          w_start_nxt = 1'b1;
          w_data_nxt  = i_req_data[8*w_pick_idx +: 8];
          w_owner_nxt = w_pick_idx;
        end
      end
      ST_LAUNCH: begin
        w_state_nxt = ST_WAIT_HI;
        w_cnt_nxt   = '0;
      end
      ST_WAIT_HI: begin
        if (i_tx_busy) begin
          w_state_nxt = ST_WAIT_LO;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          // uart_tx never acknowledged the launch: give up without a done
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!i_tx_busy) begin
          w_done_nxt  = NREQ'(1) << r_owner;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_data  <= 8'h00;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_start <= w_start_nxt;
      r_data  <= w_data_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_tx_start = r_start;
  assign o_tx_data  = r_data;
  assign o_owner    = r_owner;
  assign o_state    = r_state;

endmodule
